// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road traffic light sequencer with a per-tick
// countdown and a pedestrian request that shortens green and lights walk.
//
// Ports:
//   clk      - system clock
//   rstn     - synchronous active-low reset
//   ped_req  - pedestrian button (already synchronised), any high cycle counts
//   ns_light - north-south lamps {red, yellow, green}, one-hot
//   ew_light - east-west lamps {red, yellow, green}, one-hot
//   value    - ticks remaining in the current phase (never 0 after reset)
//   walk     - pedestrian walk lamp, only lit during an all-red phase
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned GREEN_S  = 15,
  parameter int unsigned YELLOW_S = 3,
  parameter int unsigned ALLRED_S = 1,
  parameter int unsigned PED_CUT  = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [3:0] value,
  output logic       walk
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TCNT_MAX = TW'(TICK_DIV - 1);

  localparam logic [3:0] GREEN_V  = 4'(GREEN_S);
  localparam logic [3:0] YELLOW_V = 4'(YELLOW_S);
  localparam logic [3:0] ALLRED_V = 4'(ALLRED_S);
  localparam logic [3:0] CUT_V    = 4'(PED_CUT);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Reject parameter sets that would allow 4-bit countdown wrap or a 0-length phase
  if (TICK_DIV < 2 || GREEN_S < 1 || GREEN_S > 15 || YELLOW_S < 1 || YELLOW_S > 15 ||
      ALLRED_S < 1 || ALLRED_S > 15 || PED_CUT < 1 || PED_CUT > GREEN_S) begin : g_param_err
    $error("traffic_light_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;

  state_t        state, state_nxt, succ;
  logic [3:0]    succ_dur;
  logic [3:0]    value_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          tick;
  logic          ped_pend, pend_nxt;
  logic          walk_nxt;
  logic          req_any;
  logic [2:0]    ns_nxt, ew_nxt;

  assign tick    = (tcnt == TCNT_MAX);
  assign req_any = ped_pend | ped_req;

  // Successor phase and its duration
  always_comb begin
    succ     = NS_GREEN;
    succ_dur = GREEN_V;
    case (state)
      NS_GREEN:  begin succ = NS_YELLOW; succ_dur = YELLOW_V; end
      NS_YELLOW: begin succ = ALLRED_A;  succ_dur = ALLRED_V; end
      ALLRED_A:  begin succ = EW_GREEN;  succ_dur = GREEN_V;  end
      EW_GREEN:  begin succ = EW_YELLOW; succ_dur = YELLOW_V; end
      EW_YELLOW: begin succ = ALLRED_B;  succ_dur = ALLRED_V; end
      default:   begin succ = NS_GREEN;  succ_dur = GREEN_V;  end
    endcase
  end

  // Next-state, countdown, pedestrian and lamp decode
  always_comb begin
    tcnt_nxt  = tick ? '0 : tcnt + TW'(1);
    state_nxt = state;
    value_nxt = value;
    walk_nxt  = walk;
    pend_nxt  = req_any;
    ns_nxt    = LAMP_RED;
    ew_nxt    = LAMP_RED;

    if (tick) begin
      if (value == 4'd1) begin
        state_nxt = succ;
        value_nxt = succ_dur;
        if (succ == ALLRED_A || succ == ALLRED_B) begin
          // Entering all-red serves the request, including one arriving this cycle
          walk_nxt = req_any;
          pend_nxt = 1'b0;
        end else begin
          walk_nxt = 1'b0;
        end
      end else if ((state == NS_GREEN || state == EW_GREEN) && req_any && value > CUT_V) begin
        value_nxt = CUT_V;
      end else begin
        value_nxt = value - 4'd1;
      end
    end

    case (state_nxt)
      NS_GREEN:  ns_nxt = LAMP_GREEN;
      NS_YELLOW: ns_nxt = LAMP_YELLOW;
      EW_GREEN:  ew_nxt = LAMP_GREEN;
      EW_YELLOW: ew_nxt = LAMP_YELLOW;
      default:   begin ns_nxt = LAMP_RED; ew_nxt = LAMP_RED; end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= NS_GREEN;
      value    <= GREEN_V;
      tcnt     <= '0;
      ped_pend <= 1'b0;
      walk     <= 1'b0;
      ns_light <= LAMP_GREEN;
      ew_light <= LAMP_RED;
    end else begin
      state    <= state_nxt;
      value    <= value_nxt;
      tcnt     <= tcnt_nxt;
      ped_pend <= pend_nxt;
      walk     <= walk_nxt;
      ns_light <= ns_nxt;
      ew_light <= ew_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus randomized requests
// and resets, every cycle compared against a phase-table reference model.
module tb_traffic_light_ctrl;

  localparam int TD  = 4;
  localparam int G   = 5;
  localparam int Y   = 2;
  localparam int A   = 1;
  localparam int CUT = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic [3:0] value;
  logic       walk;

  int n_checks = 0;
  int n_errors = 0;

  traffic_light_ctrl #(
    .TICK_DIV(TD), .GREEN_S(G), .YELLOW_S(Y), .ALLRED_S(A), .PED_CUT(CUT)
  ) dut (
    .clk(clk), .rstn(rstn), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .value(value), .walk(walk)
  );

  always #5 clk = ~clk;

  // Reference model: phase index into tables, seconds left, clocks into the current tick
  int         dur    [6] = '{G, Y, A, G, Y, A};
  logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_ph = 0, m_rem = G, m_t = 0;
  bit m_pend = 0, m_walk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit req, input bit rst_n);
    bit tick, want, pend_new;
    if (!rst_n) begin
      m_ph = 0; m_rem = G; m_t = 0; m_pend = 0; m_walk = 0;
    end else begin
      tick     = (m_t == TD - 1);
      m_t      = (m_t + 1) % TD;
      want     = m_pend || req;
      pend_new = want;
      if (tick) begin
        if (m_rem == 1) begin
          m_ph  = (m_ph + 1) % 6;
          m_rem = dur[m_ph];
          if (m_ph % 3 == 2) begin
            m_walk   = want;
            pend_new = 0;
          end else begin
            m_walk = 0;
          end
        end else if (m_ph % 3 == 0 && want && m_rem > CUT) begin
          m_rem = CUT;
        end else begin
          m_rem = m_rem - 1;
        end
      end
      m_pend = pend_new;
    end
  endtask

  // One clock: drive inputs, advance DUT and model, compare all outputs
  task automatic step(input bit req, input bit rst_n);
    ped_req = req;
    rstn    = rst_n;
    @(posedge clk);
    model_step(req, rst_n);
    #1;
    chk("value", 32'(value), 32'(m_rem));
    chk("ns_light", 32'(ns_light), 32'(ns_tab[m_ph]));
    chk("ew_light", 32'(ew_light), 32'(ew_tab[m_ph]));
    chk("walk", 32'(walk), 32'(m_walk));
    chk("safety", 32'((ns_light[1:0] != 2'b00) && (ew_light[1:0] != 2'b00)), 32'(0));
  endtask

  // Idle until the model reaches a given phase/remaining (and tick phase, if t >= 0)
  task automatic wait_model(input int ph, input int rem, input int t, input string tag);
    bit hit = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_ph == ph && m_rem == rem && (t < 0 || m_t == t)) begin
        hit = 1;
        break;
      end
      step(0, 1);
    end
    if (!hit) chk(tag, 32'(0), 32'(1));
  endtask

  initial begin
    int wcnt;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("rst_value", 32'(value), 32'(5));
    chk("rst_ns", 32'(ns_light), 32'(3'b001));
    chk("rst_ew", 32'(ew_light), 32'(3'b100));
    chk("rst_walk", 32'(walk), 32'(0));

    // Free run: first decrement 4 clocks after release, full cycle 64 clocks
    for (int i = 1; i <= 64; i++) begin
      step(0, 1);
      if (i == 3)  chk("hold_value", 32'(value), 32'(5));
      if (i == 4)  chk("first_dec", 32'(value), 32'(4));
      if (i == 32) chk("ew_green_at_32", 32'(ew_light), 32'(3'b001));
      if (i == 64) begin
        chk("wrap_value", 32'(value), 32'(5));
        chk("wrap_ns", 32'(ns_light), 32'(3'b001));
      end
    end

    // Pedestrian truncation at NS green value 5
    step(1, 1);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    chk("trunc_value", 32'(value), 32'(CUT));
    wcnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 1);
      if (walk) wcnt++;
    end
    chk("walk_len", 32'(wcnt), 32'(4));
    chk("after_walk_ew", 32'(ew_light), 32'(3'b001));
    chk("after_walk_walk", 32'(walk), 32'(0));

    // Late request at NS green value 2: no truncation, walk in ALLRED_A
    wait_model(0, 2, -1, "wait_late");
    step(1, 1);
    chk("late_value", 32'(value), 32'(2));
    wait_model(1, 2, -1, "wait_late_y");
    chk("late_yellow_ns", 32'(ns_light), 32'(3'b010));
    wait_model(2, 1, -1, "wait_late_ar");
    chk("late_walk", 32'(walk), 32'(1));

    // Request exactly on the ALLRED_A entry cycle
    wait_model(1, 1, TD - 1, "wait_bound");
    step(1, 1);
    chk("bound_walk", 32'(walk), 32'(1));
    chk("bound_ns", 32'(ns_light), 32'(3'b100));
    wait_model(3, 5, -1, "wait_bound_ew");
    for (int i = 0; i < 4 * G; i++) begin
      step(0, 1);
      if (i == 4 * 3) chk("bound_no_trunc", 32'(value), 32'(2));
    end
    wait_model(5, 1, -1, "wait_bound_arb");
    chk("bound_walk_b", 32'(walk), 32'(0));

    // Reset mid EW green with a request pending
    wait_model(3, 3, -1, "wait_midrst");
    step(1, 1);
    step(0, 1);
    step(0, 0);
    chk("midrst_value", 32'(value), 32'(5));
    chk("midrst_ns", 32'(ns_light), 32'(3'b001));
    chk("midrst_walk", 32'(walk), 32'(0));
    for (int i = 1; i <= 4 * 3; i++) begin
      step(0, 1);
      if (i == 12) chk("midrst_no_trunc", 32'(value), 32'(2));
    end

    // Randomized requests and occasional resets
    for (int i = 0; i < 4000; i++)
      step(($urandom % 23) == 0, ($urandom % 600) != 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
